// File: rtl/r4_sdf_pkg.sv
// +------------------------------------------------------------------+
// | Module : r4_sdf_pkg                                              |
// | Brief  : Shared constants and types for the radix-4 SDF stage    |
// |          sequencer: butterfly latency, output-mux select codes   |
// |          and the drain state encoding.                           |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
`default_nettype none

package r4_sdf_pkg;

    // Start-to-done latency of the external radix-4 butterfly pipeline.
    localparam int BFLY_LAT = 5;

    // Output mux select: out1 comes straight from the butterfly,
    // out2..out4 come back from the three output buffers.
    localparam logic [1:0] SEL_DIRECT = 2'd0;
    localparam logic [1:0] SEL_OB2    = 2'd1;
    localparam logic [1:0] SEL_OB3    = 2'd2;
    localparam logic [1:0] SEL_OB4    = 2'd3;

    // Output-buffer drain sequencer states.
    typedef enum logic [0:0] {
        DRAIN_IDLE = 1'b0,
        DRAIN_BUSY = 1'b1
    } drain_state_t;

endpackage

`default_nettype wire

// File: rtl/r4_tw_addr_gen.sv
// +------------------------------------------------------------------+
// | Module : r4_tw_addr_gen                                          |
// | Brief  : Three twiddle-index accumulators producing the ROM      |
// |          addresses for w0/w1/w2 (K*n*TW_STRIDE mod N_FFT, K=1..3)|
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
`default_nettype none

module r4_tw_addr_gen
    import r4_sdf_pkg::*;
#(
    parameter int TWAW      = 6,
    parameter int TW_STRIDE = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            step,
    output logic [TWAW-1:0] tw_addr1,
    output logic [TWAW-1:0] tw_addr2,
    output logic [TWAW-1:0] tw_addr3
);

    logic [2:0][TWAW-1:0] w_acc;

    // N_FFT is a power of two, so natural TWAW-bit wrap is the mod N_FFT.
    generate
        for (genvar k = 0; k < 3; k++) begin : g_acc
            localparam logic [TWAW-1:0] c_step = TWAW'((k + 1) * TW_STRIDE);
            logic [TWAW-1:0] r_acc;

            // Advance by K*stride per FIRE accept; return to 0 after the quarter's last sample
            always_ff @(posedge clock) begin
                if (!reset) begin
                    r_acc <= '0;
                end else if (clear) begin
                    r_acc <= '0;
                end else if (step) begin
                    r_acc <= r_acc + c_step;
                end
            end

            assign w_acc[k] = r_acc;
        end
    endgenerate

    assign tw_addr1 = w_acc[0];
    assign tw_addr2 = w_acc[1];
    assign tw_addr3 = w_acc[2];

endmodule

`default_nettype wire

// File: rtl/r4_sdf_stage_ctrl.sv
// +------------------------------------------------------------------+
// | Module : r4_sdf_stage_ctrl                                       |
// | Brief  : Sequencer for one radix-4 SDF FFT stage. Steers quarters|
// |          0-2 into delay buffers, fires the butterfly on quarter 3|
// |          with twiddle addresses, then reserializes out1 directly |
// |          and out2..out4 from the output buffers.                 |
// | Option : R4_CTRL_PERF_EN adds saturating perf_frames/perf_stalls |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
`default_nettype none

module r4_sdf_stage_ctrl #(
    parameter int N_FFT     = 64,
    parameter int DEPTH     = 16,
    parameter int TW_STRIDE = 1,
    parameter int BFLY_LAT  = r4_sdf_pkg::BFLY_LAT,
    localparam int TWAW     = $clog2(N_FFT),
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [2:0]      buf_wr_en,
    output logic [AW-1:0]   buf_addr,
    output logic [TWAW-1:0] tw_addr1,
    output logic [TWAW-1:0] tw_addr2,
    output logic [TWAW-1:0] tw_addr3,
    output logic            bfly_start,
    output logic            obuf_wr_en,
    output logic [AW-1:0]   obuf_wr_addr,
    output logic [AW-1:0]   obuf_rd_addr,
    output logic [1:0]      out_sel,
    output logic            out_valid,
    output logic            frame_done
`ifdef R4_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_frames,
    output logic [31:0]     perf_stalls
`endif
);

    import r4_sdf_pkg::*;

    localparam logic [AW+1:0] c_cnt_last = (AW+2)'(4 * DEPTH - 1);
    localparam logic [AW-1:0] c_n_last   = AW'(DEPTH - 1);

    logic               r_rdy_en;
    logic [AW+1:0]      r_cnt;
    logic [1:0]         w_q;
    logic [AW-1:0]      w_n;
    logic               w_q3;
    logic               w_accept;
    logic               w_fire;
    logic               w_tw_clear;
    logic               w_tw_step;
    logic [BFLY_LAT:0]  r_vpipe;
    logic [AW-1:0]      r_ipipe [BFLY_LAT+1];
    logic               w_pipe_exit_last;
    drain_state_t       r_drain_state;
    drain_state_t       w_drain_next;
    logic               w_rd_fire;
    logic               w_rd_last;
    logic [AW-1:0]      r_rd_addr;
    logic [1:0]         r_rd_sel;
    logic               r_dr_valid;
    logic               r_dr_last;
    logic [1:0]         r_dr_sel;

    assign w_q      = r_cnt[AW+1:AW];
    assign w_n      = r_cnt[AW-1:0];
    assign w_q3     = (w_q == 2'd3);
    // Stall only quarter 3: its out1 would otherwise collide with the
    // previous frame's drain (including the read-latency cycle).
    assign in_ready = r_rdy_en &
                      ~(w_q3 & ((r_drain_state == DRAIN_BUSY) | r_dr_valid));
    assign w_accept = in_valid & in_ready;
    assign w_fire   = w_accept & w_q3;

    // Sample counter across the 4*DEPTH frame; ready re-enables one cycle after reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rdy_en <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_accept) begin
                r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    // One-hot delay-buffer write enable for quarters 0..2
    always_comb begin
        buf_wr_en = 3'b000;
        if (w_accept && !w_q3) begin
            buf_wr_en = 3'b001 << w_q;
        end
    end

    // Same address serves as write address in FILL and sync-read address in FIRE.
    assign buf_addr = w_n;

    assign w_tw_clear = w_fire & (w_n == c_n_last);
    assign w_tw_step  = w_fire & ~w_tw_clear;

    r4_tw_addr_gen #(
        .TWAW      (TWAW),
        .TW_STRIDE (TW_STRIDE)
    ) u_tw_addr_gen (
        .clock    (clock),
        .reset    (reset),
        .clear    (w_tw_clear),
        .step     (w_tw_step),
        .tw_addr1 (tw_addr1),
        .tw_addr2 (tw_addr2),
        .tw_addr3 (tw_addr3)
    );

    // Valid/index shadow of the butterfly pipeline; stage 0 lines up with the ROM/buffer read data
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_vpipe <= '0;
            for (int i = 0; i <= BFLY_LAT; i++) begin
                r_ipipe[i] <= '0;
            end
        end else begin
            r_vpipe    <= {r_vpipe[BFLY_LAT-1:0], w_fire};
            r_ipipe[0] <= w_n;
            for (int i = 1; i <= BFLY_LAT; i++) begin
                r_ipipe[i] <= r_ipipe[i-1];
            end
        end
    end

    assign bfly_start       = r_vpipe[0];
    assign obuf_wr_en       = r_vpipe[BFLY_LAT];
    assign obuf_wr_addr     = r_vpipe[BFLY_LAT] ? r_ipipe[BFLY_LAT] : '0;
    assign w_pipe_exit_last = r_vpipe[BFLY_LAT] & (r_ipipe[BFLY_LAT] == c_n_last);

    // Drain state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_drain_state <= DRAIN_IDLE;
        end else begin
            r_drain_state <= w_drain_next;
        end
    end

    // Drain next-state: start after the last out1 is written, stop after the final read
    always_comb begin
        w_drain_next = r_drain_state;
        w_rd_fire    = 1'b0;
        w_rd_last    = 1'b0;
        case (r_drain_state)
            DRAIN_IDLE: begin
                if (w_pipe_exit_last) begin
                    w_drain_next = DRAIN_BUSY;
                end
            end
            DRAIN_BUSY: begin
                w_rd_fire = 1'b1;
                w_rd_last = (r_rd_addr == c_n_last) && (r_rd_sel == SEL_OB4);
                if (w_rd_last) begin
                    w_drain_next = DRAIN_IDLE;
                end
            end
            default: begin
                w_drain_next = DRAIN_IDLE;
            end
        endcase
    end

    // Read address sweeps 0..DEPTH-1 for each of out2, out3, out4 in turn
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rd_addr <= '0;
            r_rd_sel  <= SEL_OB2;
        end else if (w_rd_fire) begin
            if (r_rd_addr == c_n_last) begin
                r_rd_addr <= '0;
                case (r_rd_sel)
                    SEL_OB2: r_rd_sel <= SEL_OB3;
                    SEL_OB3: r_rd_sel <= SEL_OB4;
                    default: r_rd_sel <= SEL_OB2;
                endcase
            end else begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
        end
    end

    // Delay drain valid/select/last by the output-buffer read latency
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_dr_valid <= 1'b0;
            r_dr_sel   <= SEL_DIRECT;
            r_dr_last  <= 1'b0;
        end else begin
            r_dr_valid <= w_rd_fire;
            r_dr_sel   <= r_rd_sel;
            r_dr_last  <= w_rd_last;
        end
    end

    assign obuf_rd_addr = r_rd_addr;
    assign out_valid    = r_vpipe[BFLY_LAT] | r_dr_valid;
    assign out_sel      = r_vpipe[BFLY_LAT] ? SEL_DIRECT :
                          (r_dr_valid ? r_dr_sel : SEL_DIRECT);
    assign frame_done   = r_dr_valid & r_dr_last;

`ifdef R4_CTRL_PERF_EN
    logic [31:0] r_perf_frames;
    logic [31:0] r_perf_stalls;

    // Saturating frame and input-stall counters
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_perf_frames <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (frame_done && (r_perf_frames != 32'hFFFF_FFFF)) begin
                r_perf_frames <= r_perf_frames + 32'd1;
            end
            if (in_valid && !in_ready && (r_perf_stalls != 32'hFFFF_FFFF)) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign perf_frames = r_perf_frames;
    assign perf_stalls = r_perf_stalls;
`endif

endmodule

`default_nettype wire

// File: tb/tb_r4_sdf_stage_ctrl.sv
// +------------------------------------------------------------------+
// | Module : tb_r4_sdf_stage_ctrl                                    |
// | Brief  : Scoreboard bench for r4_sdf_stage_ctrl with N_FFT=16,   |
// |          DEPTH=4, TW_STRIDE=1.                                   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_r4_sdf_stage_ctrl;

    localparam int N_FFT     = 16;
    localparam int DEPTH     = 4;
    localparam int TW_STRIDE = 1;
    localparam int OUT1_LAT  = 6;   // q3 accept to out1 (BFLY_LAT + 1)

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] buf_wr_en;
    logic [1:0] buf_addr;
    logic [3:0] tw_addr1, tw_addr2, tw_addr3;
    logic       bfly_start, obuf_wr_en;
    logic [1:0] obuf_wr_addr, obuf_rd_addr, out_sel;
    logic       out_valid, frame_done;
`ifdef R4_CTRL_PERF_EN
    logic [31:0] perf_frames, perf_stalls;
`endif

    r4_sdf_stage_ctrl #(
        .N_FFT     (N_FFT),
        .DEPTH     (DEPTH),
        .TW_STRIDE (TW_STRIDE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .buf_wr_en    (buf_wr_en),
        .buf_addr     (buf_addr),
        .tw_addr1     (tw_addr1),
        .tw_addr2     (tw_addr2),
        .tw_addr3     (tw_addr3),
        .bfly_start   (bfly_start),
        .obuf_wr_en   (obuf_wr_en),
        .obuf_wr_addr (obuf_wr_addr),
        .obuf_rd_addr (obuf_rd_addr),
        .out_sel      (out_sel),
        .out_valid    (out_valid),
        .frame_done   (frame_done)
`ifdef R4_CTRL_PERF_EN
        ,
        .perf_frames  (perf_frames),
        .perf_stalls  (perf_stalls)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] sel;
        logic [1:0] addr;
        logic       done;
        int         cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         n_total = 0;
    int         n_pass  = 0;
    int         cyc     = 0;
    bit         mon_en  = 1'b0;
    logic [1:0] prev_rd_addr = 2'd0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic exp_t mk(input int sel, input int addr, input bit done, input int c);
        exp_t e;
        e.sel  = 2'(sel);
        e.addr = 2'(addr);
        e.done = done;
        e.cyc  = c;
        return e;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: pop and compare whenever the stage presents an output
    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            if (out_valid) begin
                check("sb_has_entry", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("out_sel", out_sel, e.sel);
                    if (e.sel == 2'd0) begin
                        check("obuf_wr_en", obuf_wr_en, 1);
                        check("obuf_wr_addr", obuf_wr_addr, e.addr);
                    end else begin
                        check("obuf_rd_addr", prev_rd_addr, e.addr);
                    end
                    check("frame_done", frame_done, e.done);
                    check("out_cycle", cyc, e.cyc);
                end
            end else begin
                check("frame_done_without_valid", frame_done, 0);
            end
        end
        prev_rd_addr = obuf_rd_addr;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer frame sample k until accepted; check per-accept outputs and queue expectations
    task automatic send(input int k, output int acc_c, output bit stalled);
        int waited = 0;
        int q = k / 4;
        int n = k % 4;
        in_valid = 1'b1;
        #1;
        stalled = !in_ready;
        while (!in_ready && waited < 200) begin
            @(posedge clock);
            #2;
            waited++;
        end
        check("accept_within_bound", in_ready, 1);
        acc_c = cyc;
        check("buf_wr_en", buf_wr_en, (q < 3) ? (32'd1 << q) : 32'd0);
        check("buf_addr", buf_addr, n);
        if (q == 3) begin
            check("tw_addr1", tw_addr1, (1 * n * TW_STRIDE) % N_FFT);
            check("tw_addr2", tw_addr2, (2 * n * TW_STRIDE) % N_FFT);
            check("tw_addr3", tw_addr3, (3 * n * TW_STRIDE) % N_FFT);
            sb_q.push_back(mk(0, n, 1'b0, acc_c + OUT1_LAT));
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("bfly_start", bfly_start, (q == 3) ? 1 : 0);
        if (k == 15) begin
            for (int j = 0; j < 12; j++) begin
                sb_q.push_back(mk(1 + j / 4, j % 4, j == 11, acc_c + OUT1_LAT + 2 + j));
            end
        end
    endtask

    task automatic wait_drain();
        int waited = 0;
        while (sb_q.size() != 0 && waited < 300) begin
            tick();
            waited++;
        end
        tick();
        check("drain_complete", sb_q.size(), 0);
    endtask

    task automatic check_zero();
        check("zero_in_ready", in_ready, 0);
        check("zero_buf", {buf_wr_en, buf_addr}, 0);
        check("zero_tw", {tw_addr1, tw_addr2, tw_addr3}, 0);
        check("zero_bfly_obuf", {bfly_start, obuf_wr_en, obuf_wr_addr, obuf_rd_addr}, 0);
        check("zero_out", {out_sel, out_valid, frame_done}, 0);
    endtask

    initial begin
        int  ac;
        int  base;
        bit  st;

        // Reset held low for 3 cycles
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (3) tick();
        #1;
        check_zero();
        reset = 1'b1;
        tick();
        #1;
        mon_en = 1'b1;
        check("in_ready_after_reset", in_ready, 1);
        check("no_out_valid_after_reset", out_valid, 0);

        // Two back-to-back continuous frames; frame 2 quarter 3 must stall
        base = 0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 16; k++) begin
                send(k, ac, st);
                if (f == 0 && k == 0) base = ac;
                if (f == 0 && k == 12) begin
                    check("f1_q3_no_stall", st, 0);
                    check("f1_q3_accept_cycle", ac - base, 12);
                end
                if (f == 1 && k == 12) begin
                    check("f2_q3_stalled", st, 1);
                    check("f2_q3_accept_cycle", ac - base, 35);
                end
            end
        end
        wait_drain();

        // in_valid toggling: one idle cycle after each sample
        for (int k = 0; k < 16; k++) begin
            send(k, ac, st);
            #1;
            check("idle_buf_wr_en", buf_wr_en, 0);
            tick();
        end
        wait_drain();

        // Reset in the middle of FIRE discards in-flight results
        for (int k = 0; k < 14; k++) begin
            send(k, ac, st);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        tick();
        #1;
        check_zero();
        tick();
        reset = 1'b1;
        repeat (20) tick();
        check("no_stale_outputs", sb_q.size(), 0);

        // Clean frame after the mid-frame reset
        for (int k = 0; k < 16; k++) begin
            send(k, ac, st);
        end
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
